hazard_ctrl: RTL and testbench

Pipeline hazard controller that drives the flush and hold controls consumed by the IF/ID, ID/EX and EX/MEM stage registers.
- Watches the ID/EX outputs (MemRead2, Rd2) and the source registers of the instruction in IF/ID, and inserts load-use bubbles.
- Flushes wrong-path stages when a branch is resolved taken in MEM.
- Freezes the whole pipeline while data memory is busy.
- Keeps saturating stall and flush statistics counters.

---
 rtl/hazard_ctrl_pkg.sv | 32 +++
 rtl/hazard_ctrl_if.sv | 41 ++++
 rtl/hazard_ctrl_sat_counter.sv | 23 ++
 rtl/hazard_ctrl.sv | 124 ++++++++++++
 tb/tb_hazard_ctrl.sv | 382 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared pipeline definitions for the hazard controller.
//   - FSM state encoding (RUN / LU_STALL)
//   - register-index width and the x0 index
//   - default statistics counter width and bubble counter width
//   - load-use hazard detection helper
package hazard_ctrl_pkg;

   localparam int REG_W     = 5;
   localparam int CNT_W_DEF = 16;
   localparam int BUB_W     = 3;

   localparam logic [REG_W-1:0] REG_X0 = '0;

   typedef enum logic {
      ST_RUN      = 1'b0,
      ST_LU_STALL = 1'b1
   } hz_state_e;

   // x0 is hard-wired zero, so a load targeting it can never create a dependence.
   function automatic logic lu_hazard(
      input logic             mem_read,
      input logic [REG_W-1:0] rd,
      input logic             use_rs1,
      input logic [REG_W-1:0] rs1,
      input logic             use_rs2,
      input logic [REG_W-1:0] rs2
   );
      return mem_read && (rd != REG_X0) &&
             ((use_rs1 && (rs1 == rd)) || (use_rs2 && (rs2 == rd)));
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline-side signals exchanged with the hazard controller.
//   Observed by the controller: IF/ID source fields, ID/EX load info,
//   EX/MEM branch outcome, data memory busy.
//   Driven by the controller: stage write enables and stage flushes.
//   master : pipeline side (drives observations, receives controls)
//   slave  : hazard controller
interface hazard_ctrl_if;
   import hazard_ctrl_pkg::*;

   logic [REG_W-1:0] ifid_rs1;
   logic [REG_W-1:0] ifid_rs2;
   logic             ifid_use_rs1;
   logic             ifid_use_rs2;
   logic             idex_mem_read;
   logic [REG_W-1:0] idex_rd;
   logic             exmem_branch_taken;
   logic             dmem_busy;

   logic             pc_write;
   logic             ifid_write;
   logic             idex_write;
   logic             exmem_write;
   logic             flush_IFID;
   logic             flush_IDEX;
   logic             flush_EXMEM;

   modport master (
      output ifid_rs1, ifid_rs2, ifid_use_rs1, ifid_use_rs2,
             idex_mem_read, idex_rd, exmem_branch_taken, dmem_busy,
      input  pc_write, ifid_write, idex_write, exmem_write,
             flush_IFID, flush_IDEX, flush_EXMEM
   );

   modport slave (
      input  ifid_rs1, ifid_rs2, ifid_use_rs1, ifid_use_rs2,
             idex_mem_read, idex_rd, exmem_branch_taken, dmem_busy,
      output pc_write, ifid_write, idex_write, exmem_write,
             flush_IFID, flush_IDEX, flush_EXMEM
   );

endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// sat_counter: width-parameterised up-counter that sticks at all-ones.
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset, clears the count
//   en    : count enable
//   cnt   : current count
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (en && (cnt != {W{1'b1}})) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller.
//   Inserts load-use bubbles, flushes wrong-path stages on a taken branch
//   resolved in MEM, freezes the pipeline while data memory is busy, and
//   keeps saturating stall / flush statistics.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   RUN      | normal flow; a load-use hazard here inserts bubble 1
//   LU_STALL | inserting the remaining bubbles (count held in bub_cnt)
//
// Ports:
//   clk        : pipeline clock, rising edge
//   reset      : asynchronous active-low reset
//   hz         : pipeline signals (slave modport of hazard_ctrl_if)
//   stall_cnt  : bubble cycles inserted (saturating)
//   flush_cnt  : branch flush events (saturating)
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int LOAD_BUBBLES = 1,
   parameter int CNT_W        = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   hazard_ctrl_if.slave     hz,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   hz_state_e        state, state_nxt;
   logic [BUB_W-1:0] bub_cnt, bub_nxt;
   logic             stall_inc;
   logic             flush_inc;
   logic             hazard;

   assign hazard = lu_hazard(hz.idex_mem_read, hz.idex_rd,
                             hz.ifid_use_rs1, hz.ifid_rs1,
                             hz.ifid_use_rs2, hz.ifid_rs2);

   always_comb begin
      hz.pc_write    = 1'b1;
      hz.ifid_write  = 1'b1;
      hz.idex_write  = 1'b1;
      hz.exmem_write = 1'b1;
      hz.flush_IFID  = 1'b0;
      hz.flush_IDEX  = 1'b0;
      hz.flush_EXMEM = 1'b0;
      stall_inc      = 1'b0;
      flush_inc      = 1'b0;
      state_nxt      = state;
      bub_nxt        = bub_cnt;

      if (hz.dmem_busy) begin
         // Freeze: stage contents are held, so a pending branch or hazard is
         // still presented once the memory releases.
         hz.pc_write    = 1'b0;
         hz.ifid_write  = 1'b0;
         hz.idex_write  = 1'b0;
         hz.exmem_write = 1'b0;
      end else if (hz.exmem_branch_taken) begin
         hz.flush_IFID  = 1'b1;
         hz.flush_IDEX  = 1'b1;
         hz.flush_EXMEM = 1'b1;
         flush_inc      = 1'b1;
         state_nxt      = ST_RUN;
         bub_nxt        = '0;
      end else if (state == ST_LU_STALL) begin
         hz.pc_write   = 1'b0;
         hz.ifid_write = 1'b0;
         hz.flush_IDEX = 1'b1;
         stall_inc     = 1'b1;
         bub_nxt       = bub_cnt - BUB_W'(1);
         if (bub_cnt <= BUB_W'(1)) begin
            state_nxt = ST_RUN;
         end
      end else if (hazard) begin
         hz.pc_write   = 1'b0;
         hz.ifid_write = 1'b0;
         hz.flush_IDEX = 1'b1;
         stall_inc     = 1'b1;
         // The first bubble is this cycle; the rest are counted down in LU_STALL.
         if (LOAD_BUBBLES > 1) begin
            state_nxt = ST_LU_STALL;
            bub_nxt   = BUB_W'(LOAD_BUBBLES - 1);
         end
      end

      // Reset forces safe controls immediately, without waiting for a clock.
      if (!reset) begin
         hz.pc_write    = 1'b0;
         hz.ifid_write  = 1'b0;
         hz.idex_write  = 1'b0;
         hz.exmem_write = 1'b0;
         hz.flush_IFID  = 1'b1;
         hz.flush_IDEX  = 1'b1;
         hz.flush_EXMEM = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= ST_RUN;
         bub_cnt <= '0;
      end else begin
         state   <= state_nxt;
         bub_cnt <= bub_nxt;
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .en    (stall_inc),
      .cnt   (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .reset (reset),
      .en    (flush_inc),
      .cnt   (flush_cnt)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

   logic clk;
   logic rst;
   logic [4:0] rs1, rs2, rd;
   logic u1, u2, mr, br, busy;

   hazard_ctrl_if if_a();
   hazard_ctrl_if if_b();
   hazard_ctrl_if if_c();

   logic [15:0] stall_a, flush_a, stall_b, flush_b;
   logic [1:0]  stall_c, flush_c;

   hazard_ctrl #(.LOAD_BUBBLES(1), .CNT_W(16)) dut_a (
      .clk(clk), .reset(rst), .hz(if_a), .stall_cnt(stall_a), .flush_cnt(flush_a));
   hazard_ctrl #(.LOAD_BUBBLES(3), .CNT_W(16)) dut_b (
      .clk(clk), .reset(rst), .hz(if_b), .stall_cnt(stall_b), .flush_cnt(flush_b));
   hazard_ctrl #(.LOAD_BUBBLES(1), .CNT_W(2)) dut_c (
      .clk(clk), .reset(rst), .hz(if_c), .stall_cnt(stall_c), .flush_cnt(flush_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   // Reference model: bubbles still owed and event totals per instance.
   int lb[3]   = '{1, 3, 1};
   int cmax[3] = '{65535, 65535, 3};
   int m_rem[3];
   int m_stall[3];
   int m_flush[3];

   function automatic logic hz_now();
      if (!mr || rd == 5'd0) return 1'b0;
      return (u1 && rs1 == rd) || (u2 && rs2 == rd);
   endfunction

   // {pc, ifid, idex, exmem, flush_IFID, flush_IDEX, flush_EXMEM}
   function automatic logic [6:0] model_ctl(int k);
      if (!rst) return 7'b0000111;
      if (busy) return 7'b0000000;
      if (br) return 7'b1111111;
      if (m_rem[k] > 0 || hz_now()) return 7'b0011010;
      return 7'b1111000;
   endfunction

   function automatic logic [6:0] dut_ctl(int k);
      case (k)
         0: return {if_a.pc_write, if_a.ifid_write, if_a.idex_write, if_a.exmem_write,
                    if_a.flush_IFID, if_a.flush_IDEX, if_a.flush_EXMEM};
         1: return {if_b.pc_write, if_b.ifid_write, if_b.idex_write, if_b.exmem_write,
                    if_b.flush_IFID, if_b.flush_IDEX, if_b.flush_EXMEM};
         default: return {if_c.pc_write, if_c.ifid_write, if_c.idex_write, if_c.exmem_write,
                          if_c.flush_IFID, if_c.flush_IDEX, if_c.flush_EXMEM};
      endcase
   endfunction

   function automatic logic [31:0] dut_stall(int k);
      case (k)
         0: return {16'd0, stall_a};
         1: return {16'd0, stall_b};
         default: return {30'd0, stall_c};
      endcase
   endfunction

   function automatic logic [31:0] dut_flush(int k);
      case (k)
         0: return {16'd0, flush_a};
         1: return {16'd0, flush_b};
         default: return {30'd0, flush_c};
      endcase
   endfunction

   task automatic set_in(input logic r, input logic i_mr, input logic [4:0] i_rd,
                         input logic [4:0] i_rs1, input logic i_u1,
                         input logic [4:0] i_rs2, input logic i_u2,
                         input logic i_br, input logic i_busy);
      rst = r; mr = i_mr; rd = i_rd; rs1 = i_rs1; u1 = i_u1;
      rs2 = i_rs2; u2 = i_u2; br = i_br; busy = i_busy;
      if_a.idex_mem_read = mr; if_b.idex_mem_read = mr; if_c.idex_mem_read = mr;
      if_a.idex_rd = rd;       if_b.idex_rd = rd;       if_c.idex_rd = rd;
      if_a.ifid_rs1 = rs1;     if_b.ifid_rs1 = rs1;     if_c.ifid_rs1 = rs1;
      if_a.ifid_rs2 = rs2;     if_b.ifid_rs2 = rs2;     if_c.ifid_rs2 = rs2;
      if_a.ifid_use_rs1 = u1;  if_b.ifid_use_rs1 = u1;  if_c.ifid_use_rs1 = u1;
      if_a.ifid_use_rs2 = u2;  if_b.ifid_use_rs2 = u2;  if_c.ifid_use_rs2 = u2;
      if_a.exmem_branch_taken = br; if_b.exmem_branch_taken = br; if_c.exmem_branch_taken = br;
      if_a.dmem_busy = busy;   if_b.dmem_busy = busy;   if_c.dmem_busy = busy;
      if (!r) begin
         for (int k = 0; k < 3; k++) begin
            m_rem[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
         end
      end
   endtask

   task automatic set_quiet();
      set_in(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic set_hazard(input logic [4:0] r_d);
      set_in(1'b1, 1'b1, r_d, 5'd0, 1'b0, r_d, 1'b1, 1'b0, 1'b0);
   endtask

   // Advance the model with the inputs present at this edge, then the clock.
   task automatic tick();
      for (int k = 0; k < 3; k++) begin
         if (!rst) begin
            m_rem[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
         end else if (busy) begin
         end else if (br) begin
            if (m_flush[k] < cmax[k]) m_flush[k]++;
            m_rem[k] = 0;
         end else if (m_rem[k] > 0) begin
            if (m_stall[k] < cmax[k]) m_stall[k]++;
            m_rem[k]--;
         end else if (hz_now()) begin
            if (m_stall[k] < cmax[k]) m_stall[k]++;
            m_rem[k] = lb[k] - 1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      set_in(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      tick();
   endtask

   task automatic test_reset();
      for (int c = 0; c < 3; c++) begin
         set_in(1'b0, 1'($urandom_range(0, 1)), 5'($urandom), 5'($urandom), 1'($urandom_range(0, 1)),
                5'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         #2;
         for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (dut_ctl(k) !== 7'b0000111) begin
               n_fail++; $display("FAIL reset_ctl dut%0d got %b exp 0000111", k, dut_ctl(k));
            end
            n_chk++;
            if (dut_stall(k) !== 0 || dut_flush(k) !== 0) begin
               n_fail++; $display("FAIL reset_cnt dut%0d got %0d/%0d exp 0/0", k, dut_stall(k), dut_flush(k));
            end
         end
         tick();
      end
      set_quiet();
      #2;
      for (int k = 0; k < 3; k++) begin
         n_chk++;
         if (dut_ctl(k) !== 7'b1111000) begin
            n_fail++; $display("FAIL release_ctl dut%0d got %b exp 1111000", k, dut_ctl(k));
         end
      end
      tick();
   endtask

   task automatic test_lu_single();
      pulse_reset();
      set_hazard(5'd5);
      #2;
      for (int k = 0; k < 3; k++) begin
         n_chk++;
         if (dut_ctl(k) !== 7'b0011010) begin
            n_fail++; $display("FAIL lu1_bubble dut%0d got %b exp 0011010", k, dut_ctl(k));
         end
      end
      tick();
      set_quiet();
      #2;
      n_chk++;
      if (dut_ctl(0) !== 7'b1111000) begin
         n_fail++; $display("FAIL lu1_after got %b exp 1111000", dut_ctl(0));
      end
      n_chk++;
      if (dut_stall(0) !== 1) begin
         n_fail++; $display("FAIL lu1_stall_cnt got %0d exp 1", dut_stall(0));
      end
      tick();
   endtask

   task automatic test_lu_multi();
      pulse_reset();
      for (int i = 0; i < 4; i++) begin
         if (i == 0) set_in(1'b1, 1'b1, 5'd9, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
         else set_quiet();
         #2;
         n_chk++;
         if (dut_ctl(1) !== (i < 3 ? 7'b0011010 : 7'b1111000)) begin
            n_fail++; $display("FAIL lu3_cycle%0d got %b exp %b", i, dut_ctl(1), model_ctl(1));
         end
         n_chk++;
         if (dut_stall(1) !== i) begin
            n_fail++; $display("FAIL lu3_stall_cnt cycle%0d got %0d exp %0d", i, dut_stall(1), i);
         end
         tick();
      end
   endtask

   task automatic test_branch_in_stall();
      pulse_reset();
      set_hazard(5'd7);
      tick();
      set_in(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      #2;
      for (int k = 0; k < 3; k++) begin
         n_chk++;
         if (dut_ctl(k) !== 7'b1111111) begin
            n_fail++; $display("FAIL br_flush dut%0d got %b exp 1111111", k, dut_ctl(k));
         end
      end
      tick();
      set_quiet();
      #2;
      n_chk++;
      if (dut_ctl(1) !== 7'b1111000) begin
         n_fail++; $display("FAIL br_abort got %b exp 1111000", dut_ctl(1));
      end
      n_chk++;
      if (dut_stall(1) !== 1 || dut_flush(1) !== 1) begin
         n_fail++; $display("FAIL br_counts got %0d/%0d exp 1/1", dut_stall(1), dut_flush(1));
      end
      tick();
   endtask

   task automatic test_freeze();
      pulse_reset();
      for (int i = 0; i < 4; i++) begin
         set_in(1'b1, 1'b1, 5'd3, 5'd3, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1);
         #2;
         for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (dut_ctl(k) !== 7'b0000000 || dut_flush(k) !== 0 || dut_stall(k) !== 0) begin
               n_fail++; $display("FAIL freeze dut%0d got %b %0d/%0d exp 0000000 0/0",
                                  k, dut_ctl(k), dut_stall(k), dut_flush(k));
            end
         end
         tick();
      end
      set_in(1'b1, 1'b1, 5'd3, 5'd3, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0);
      #2;
      n_chk++;
      if (dut_ctl(0) !== 7'b1111111) begin
         n_fail++; $display("FAIL unfreeze_flush got %b exp 1111111", dut_ctl(0));
      end
      tick();
      set_quiet();
      #2;
      n_chk++;
      if (dut_flush(0) !== 1 || dut_stall(0) !== 0) begin
         n_fail++; $display("FAIL unfreeze_counts got %0d/%0d exp 0/1", dut_stall(0), dut_flush(0));
      end
      tick();
   endtask

   task automatic test_x0_sat();
      pulse_reset();
      set_in(1'b1, 1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
      #2;
      for (int k = 0; k < 3; k++) begin
         n_chk++;
         if (dut_ctl(k) !== 7'b1111000) begin
            n_fail++; $display("FAIL x0_nostall dut%0d got %b exp 1111000", k, dut_ctl(k));
         end
      end
      tick();
      for (int i = 0; i < 10; i++) begin
         if (i % 2 == 0) set_hazard(5'd12);
         else set_quiet();
         #2;
         n_chk++;
         if (dut_ctl(2) !== model_ctl(2)) begin
            n_fail++; $display("FAIL sat_ctl cycle%0d got %b exp %b", i, dut_ctl(2), model_ctl(2));
         end
         tick();
      end
      set_quiet();
      #2;
      n_chk++;
      if (dut_stall(2) !== 3) begin
         n_fail++; $display("FAIL sat_stall_cnt got %0d exp 3", dut_stall(2));
      end
      n_chk++;
      if (dut_stall(0) !== 5) begin
         n_fail++; $display("FAIL wide_stall_cnt got %0d exp 5", dut_stall(0));
      end
      tick();
   endtask

   task automatic test_async_reset_mid_stall();
      pulse_reset();
      set_hazard(5'd4);
      tick();
      set_quiet();
      #2;
      n_chk++;
      if (dut_ctl(1) !== 7'b0011010) begin
         n_fail++; $display("FAIL midstall_bubble got %b exp 0011010", dut_ctl(1));
      end
      #1;
      set_in(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      #1;
      for (int k = 0; k < 3; k++) begin
         n_chk++;
         if (dut_ctl(k) !== 7'b0000111 || dut_stall(k) !== 0) begin
            n_fail++; $display("FAIL async_reset dut%0d got %b %0d exp 0000111 0", k, dut_ctl(k), dut_stall(k));
         end
      end
      tick();
      set_quiet();
      #2;
      n_chk++;
      if (dut_ctl(1) !== 7'b1111000) begin
         n_fail++; $display("FAIL after_reset_run got %b exp 1111000", dut_ctl(1));
      end
      tick();
   endtask

   task automatic test_back_to_back();
      pulse_reset();
      for (int i = 0; i < 5; i++) begin
         set_hazard(5'd17);
         #2;
         for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (dut_ctl(k) !== 7'b0011010) begin
               n_fail++; $display("FAIL b2b_bubble dut%0d cycle%0d got %b exp 0011010", k, i, dut_ctl(k));
            end
         end
         tick();
      end
      set_quiet();
      #2;
      n_chk++;
      if (dut_stall(0) !== 5 || dut_stall(1) !== 5) begin
         n_fail++; $display("FAIL b2b_counts got %0d/%0d exp 5/5", dut_stall(0), dut_stall(1));
      end
      tick();
   endtask

   task automatic test_random();
      pulse_reset();
      for (int i = 0; i < 600; i++) begin
         set_in(1'($urandom_range(0, 49) != 0), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 6) == 0));
         #2;
         for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (dut_ctl(k) !== model_ctl(k)) begin
               n_fail++; $display("FAIL rnd_ctl dut%0d cycle%0d got %b exp %b", k, i, dut_ctl(k), model_ctl(k));
            end
            n_chk++;
            if (dut_stall(k) !== m_stall[k] || dut_flush(k) !== m_flush[k]) begin
               n_fail++; $display("FAIL rnd_cnt dut%0d cycle%0d got %0d/%0d exp %0d/%0d",
                                  k, i, dut_stall(k), dut_flush(k), m_stall[k], m_flush[k]);
            end
         end
         tick();
      end
   endtask

   initial begin
      set_in(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      test_reset();
      test_lu_single();
      test_lu_multi();
      test_branch_in_stall();
      test_freeze();
      test_x0_sat();
      test_async_reset_mid_stall();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
